bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 BIN_W, 16, binary input width (>=4) SHALL be a parameter.
REQ-002 DIGITS, 5, BCD digits produced (>=2) SHALL be a parameter.
REQ-003 SIGNED_EN, 0, 1 = bin_i treated as two's complement SHALL be a parameter.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 valid_i  in  1  request; accepted when valid_i & ready_o at a clk edge.
REQ-007 bin_i  in  BIN_W  value, sampled at accept.
REQ-008 blank_en_i  in  1  leading-zero blanking enable, sampled at accept.
REQ-009 ready_o  out  1  high only in S_IDLE.
REQ-010 valid_o  out  1  one-cycle result strobe.
REQ-011 digits_o  out  4*DIGITS  BCD result, digit 0 in [3:0]; held until next valid_o.
REQ-012 blank_o  out  DIGITS  per-digit blank mask; held with digits_o.
REQ-013 neg_o  out  1  result negative; held.
REQ-014 ovf_o  out  1  magnitude >= 10^DIGITS; held.
REQ-015 digit_o  out  4  serial digit during S_EMIT, else 0.
REQ-016 digit_sel_o  out  DIGITS  one-hot serial digit index during S_EMIT, else 0.

Function
REQ-017 FSM SHALL have states S_IDLE, S_CONV, S_FLAG, S_EMIT: IDLE->CONV on accept; CONV->FLAG after BIN_W shift cycles; FLAG->EMIT; EMIT->IDLE after DIGITS cycles.
REQ-018 At accept: magnitude = bin_i, or two's-complement negation of bin_i when SIGNED_EN=1 and bin_i[BIN_W-1]=1 (neg latched 1); magnitude held in BIN_W unsigned bits (most-negative value fits); BCD register cleared; ovf sticky cleared.
REQ-019 Each S_CONV cycle: every digit >4 gets +3 (all digits in parallel), then BCD||magnitude shifted left 1 bit; one bit per cycle, MSB first.
REQ-020 A 1 shifted out of the top digit SHALL set the sticky ovf; digits_o then holds the low DIGITS digits of the value.
REQ-021 S_FLAG SHALL register digits_o, neg_o, ovf_o, blank_o; valid_o SHALL be high for exactly the cycle after the S_FLAG edge, i.e. BIN_W+1 edges after the accepting edge.
REQ-022 Blanking: when latched blank_en=1 and ovf=0, digits above the most significant non-zero digit SHALL be blanked; digit 0 is never blanked; otherwise blank_o=0.
REQ-023 S_EMIT SHALL present digit k on digit_o with digit_sel_o=1<<k for k=0..DIGITS-1 in successive cycles, starting in the valid_o cycle.
REQ-024 valid_i while ready_o=0 SHALL be ignored (no queueing); next accept earliest in the first S_IDLE cycle after S_EMIT.
REQ-025 Throughput: one conversion per BIN_W+DIGITS+2 cycles.

Reset
REQ-026 rst_n low SHALL immediately force S_IDLE and all outputs and internal registers to 0 (ready_o=1 once in S_IDLE), including mid-conversion; an aborted conversion produces no valid_o.

Structure
REQ-027 Package bin2bcd_pkg SHALL hold the state enum type and a digit-index width constant/function ($clog2(DIGITS) based).
REQ-028 Combinational sub-module bcd_dabble_step (DIGITS-parameterised add-3 + shift, outputs shifted-out carry) SHALL implement REQ-019/020.

Verification
REQ-029 Defaults, bin_i=16'hFFFF -> digits_o=20'h65535, ovf_o=0, neg_o=0, valid_o exactly 17 edges after accept.
REQ-030 bin_i=0, blank_en_i=1 -> digits_o=0, blank_o=5'b11110; bin_i=305 -> blank_o=5'b11000.
REQ-031 DIGITS=4, bin_i=12345 -> ovf_o=1, digits_o=16'h2345, blank_o=0.
REQ-032 SIGNED_EN=1, bin_i=16'h8000 -> neg_o=1, digits_o=20'h32768; bin_i=16'hFFFF -> neg_o=1, digits_o=1.
REQ-033 For 65535: digit_sel_o 00001,00010,00100,01000,10000 on consecutive cycles with digit_o 5,3,5,5,6, then both 0 and ready_o=1.
REQ-034 valid_i held high throughout -> one accept per BIN_W+DIGITS+2 cycles; rst_n pulsed mid-S_CONV -> all outputs 0, no valid_o, ready_o=1 after release.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared FSM state type and digit-index sizing for bin2bcd_seq
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FLAG = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    function automatic int digit_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble.sv
// rtl/bin2bcd_seq_dabble.sv - one double-dabble step: add-3 on every digit above 4, then shift in one bit
module bcd_dabble_step #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic                bit_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                carry_o
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (bcd_i[4*k +: 4] > 4'd4) ? (bcd_i[4*k +: 4] + 4'd3) : bcd_i[4*k +: 4];
        end
    end

    // The bit leaving the top digit means the value no longer fits in DIGITS digits.
    assign bcd_o   = {adj[4*DIGITS-2:0], bit_i};
    assign carry_o = adj[4*DIGITS-1];

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter with blanking, overflow and serial digit emit
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_EN = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [BIN_W-1:0]    bin_i,
    input  logic                blank_en_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [4*DIGITS-1:0] digits_o,
    output logic [DIGITS-1:0]   blank_o,
    output logic                neg_o,
    output logic                ovf_o,
    output logic [3:0]          digit_o,
    output logic [DIGITS-1:0]   digit_sel_o
);

    localparam int IDX_W = digit_idx_w(DIGITS);
    localparam int CNT_W = $clog2(BIN_W);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    emit_idx;
    logic [IDX_W-1:0]    next_idx;
    logic [BIN_W-1:0]    mag_q;
    logic [BIN_W-1:0]    mag_in;
    logic                neg_in;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_next;
    logic                carry;
    logic                ovf_q;
    logic                neg_q;
    logic                blank_en_q;
    logic [DIGITS-1:0]   blank_next;
    logic                zero_above;
    logic                accept;
    logic                conv_last;
    logic                emit_last;

    assign ready_o   = (state == S_IDLE);
    assign accept    = valid_i & ready_o;
    assign conv_last = (cnt == CNT_W'(BIN_W - 1));
    assign emit_last = (emit_idx == IDX_W'(DIGITS - 1));
    assign next_idx  = emit_idx + IDX_W'(1);

    // Most-negative input still fits because the magnitude is held unsigned.
    assign neg_in = (SIGNED_EN != 0) && bin_i[BIN_W-1];
    assign mag_in = neg_in ? (~bin_i + BIN_W'(1)) : bin_i;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_i   (bcd_q),
        .bit_i   (mag_q[BIN_W-1]),
        .bcd_o   (bcd_next),
        .carry_o (carry)
    );

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above & (bcd_q[4*k +: 4] == 4'd0);
            blank_next[k] = zero_above & blank_en_q & ~ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)    state_next = S_CONV;
            S_CONV:  if (conv_last) state_next = S_FLAG;
            S_FLAG:                 state_next = S_EMIT;
            S_EMIT:  if (emit_last) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            emit_idx    <= '0;
            mag_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            blank_en_q  <= 1'b0;
            valid_o     <= 1'b0;
            digits_o    <= '0;
            blank_o     <= '0;
            neg_o       <= 1'b0;
            ovf_o       <= 1'b0;
            digit_o     <= '0;
            digit_sel_o <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        mag_q      <= mag_in;
                        neg_q      <= neg_in;
                        blank_en_q <= blank_en_i;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                S_CONV: begin
                    cnt   <= cnt + CNT_W'(1);
                    mag_q <= mag_q << 1;
                    bcd_q <= bcd_next;
                    ovf_q <= ovf_q | carry;
                end
                S_FLAG: begin
                    valid_o     <= 1'b1;
                    digits_o    <= bcd_q;
                    blank_o     <= blank_next;
                    neg_o       <= neg_q;
                    ovf_o       <= ovf_q;
                    emit_idx    <= '0;
                    digit_o     <= bcd_q[3:0];
                    digit_sel_o <= DIGITS'(1);
                end
                S_EMIT: begin
                    if (emit_last) begin
                        digit_o     <= '0;
                        digit_sel_o <= '0;
                    end else begin
                        emit_idx    <= next_idx;
                        digit_o     <= digits_o[{next_idx, 2'b00} +: 4];
                        digit_sel_o <= digit_sel_o << 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // instance 0: defaults
    logic        valid0 = 1'b0;
    logic [15:0] bin0 = '0;
    logic        blank_en0 = 1'b0;
    logic        ready0, vout0, neg0, ovf0;
    logic [19:0] digits0;
    logic [4:0]  blnk0, sel0;
    logic [3:0]  dig0;

    // instance 1: DIGITS=4
    logic        valid1 = 1'b0;
    logic [15:0] bin1 = '0;
    logic        blank_en1 = 1'b0;
    logic        ready1, vout1, neg1, ovf1;
    logic [15:0] digits1;
    logic [3:0]  blnk1, sel1;
    logic [3:0]  dig1;

    // instance 2: SIGNED_EN=1
    logic        valid2 = 1'b0;
    logic [15:0] bin2 = '0;
    logic        blank_en2 = 1'b0;
    logic        ready2, vout2, neg2, ovf2;
    logic [19:0] digits2;
    logic [4:0]  blnk2, sel2;
    logic [3:0]  dig2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid0), .bin_i(bin0), .blank_en_i(blank_en0),
        .ready_o(ready0), .valid_o(vout0), .digits_o(digits0), .blank_o(blnk0),
        .neg_o(neg0), .ovf_o(ovf0), .digit_o(dig0), .digit_sel_o(sel0)
    );

    bin2bcd_seq #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid1), .bin_i(bin1), .blank_en_i(blank_en1),
        .ready_o(ready1), .valid_o(vout1), .digits_o(digits1), .blank_o(blnk1),
        .neg_o(neg1), .ovf_o(ovf1), .digit_o(dig1), .digit_sel_o(sel1)
    );

    bin2bcd_seq #(.SIGNED_EN(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid_i(valid2), .bin_i(bin2), .blank_en_i(blank_en2),
        .ready_o(ready2), .valid_o(vout2), .digits_o(digits2), .blank_o(blnk2),
        .neg_o(neg2), .ovf_o(ovf2), .digit_o(dig2), .digit_sel_o(sel2)
    );

    // Launch one conversion on the chosen instance; lat = edges from accept to valid_o (0 on timeout).
    task automatic run(input int which, input logic [15:0] b, input logic bl, output int lat);
        logic rdy;
        logic vo;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            rdy = (which == 0) ? ready0 : (which == 1) ? ready1 : ready2;
            if (rdy) break;
        end
        case (which)
            0: begin valid0 = 1'b1; bin0 = b; blank_en0 = bl; end
            1: begin valid1 = 1'b1; bin1 = b; blank_en1 = bl; end
            default: begin valid2 = 1'b1; bin2 = b; blank_en2 = bl; end
        endcase
        @(posedge clk); #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            vo = (which == 0) ? vout0 : (which == 1) ? vout1 : vout2;
            if (vo) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready0, vout0, neg0, ovf0} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 1000", {ready0, vout0, neg0, ovf0});
        end
        checks++;
        if ({digits0, blnk0, dig0, sel0} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%b/%h/%b want 0", digits0, blnk0, dig0, sel0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max_and_emit;
        int lat;
        logic [3:0] exp_dig [5];
        exp_dig[0] = 4'd5; exp_dig[1] = 4'd3; exp_dig[2] = 4'd5; exp_dig[3] = 4'd5; exp_dig[4] = 4'd6;
        run(0, 16'hFFFF, 1'b0, lat);
        checks++;
        if (lat != 17) begin
            failures++;
            $display("FAIL max_latency: got %0d want 17", lat);
        end
        checks++;
        if ({digits0, ovf0, neg0, blnk0} !== {20'h65535, 1'b0, 1'b0, 5'b0}) begin
            failures++;
            $display("FAIL max_result: got %h ovf=%b neg=%b blank=%b want 65535 0 0 00000", digits0, ovf0, neg0, blnk0);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if (dig0 !== exp_dig[k] || sel0 !== (5'd1 << k)) begin
                failures++;
                $display("FAIL emit_%0d: got digit=%h sel=%b want digit=%h sel=%b", k, dig0, sel0, exp_dig[k], 5'd1 << k);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (dig0 !== 4'd0 || sel0 !== 5'd0 || ready0 !== 1'b1 || digits0 !== 20'h65535) begin
            failures++;
            $display("FAIL emit_end: got digit=%h sel=%b ready=%b digits=%h want 0 00000 1 65535", dig0, sel0, ready0, digits0);
        end
    endtask

    task automatic test_blank;
        int lat;
        run(0, 16'd0, 1'b1, lat);
        checks++;
        if (digits0 !== 20'h0 || blnk0 !== 5'b11110) begin
            failures++;
            $display("FAIL blank_zero: got %h/%b want 00000/11110", digits0, blnk0);
        end
        run(0, 16'd305, 1'b1, lat);
        checks++;
        if (digits0 !== 20'h00305 || blnk0 !== 5'b11000) begin
            failures++;
            $display("FAIL blank_305: got %h/%b want 00305/11000", digits0, blnk0);
        end
        run(0, 16'd305, 1'b0, lat);
        checks++;
        if (blnk0 !== 5'b00000) begin
            failures++;
            $display("FAIL blank_off: got %b want 00000", blnk0);
        end
    endtask

    task automatic test_ovf;
        int lat;
        run(1, 16'd12345, 1'b1, lat);
        checks++;
        if (lat != 17 || ovf1 !== 1'b1 || digits1 !== 16'h2345 || blnk1 !== 4'b0 || neg1 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_12345: got lat=%0d ovf=%b %h blank=%b neg=%b want 17 1 2345 0000 0", lat, ovf1, digits1, blnk1, neg1);
        end
        run(1, 16'd9999, 1'b1, lat);
        checks++;
        if (ovf1 !== 1'b0 || digits1 !== 16'h9999) begin
            failures++;
            $display("FAIL ovf_9999: got ovf=%b %h want 0 9999", ovf1, digits1);
        end
        run(1, 16'd10000, 1'b1, lat);
        checks++;
        if (ovf1 !== 1'b1 || digits1 !== 16'h0000 || blnk1 !== 4'b0) begin
            failures++;
            $display("FAIL ovf_10000: got ovf=%b %h blank=%b want 1 0000 0000", ovf1, digits1, blnk1);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dig1 !== 4'd0 || sel1 !== 4'd0 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_idle: got digit=%h sel=%b ready=%b want 0 0000 1", dig1, sel1, ready1);
        end
    endtask

    task automatic test_signed;
        int lat;
        run(2, 16'h8000, 1'b0, lat);
        checks++;
        if (neg2 !== 1'b1 || digits2 !== 20'h32768 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL signed_min: got neg=%b %h ovf=%b want 1 32768 0", neg2, digits2, ovf2);
        end
        run(2, 16'hFFFF, 1'b1, lat);
        checks++;
        if (neg2 !== 1'b1 || digits2 !== 20'h00001 || blnk2 !== 5'b11110) begin
            failures++;
            $display("FAIL signed_m1: got neg=%b %h blank=%b want 1 00001 11110", neg2, digits2, blnk2);
        end
        run(2, 16'h7FFF, 1'b0, lat);
        checks++;
        if (neg2 !== 1'b0 || digits2 !== 20'h32767) begin
            failures++;
            $display("FAIL signed_max: got neg=%b %h want 0 32767", neg2, digits2);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dig2 !== 4'd0 || sel2 !== 5'd0 || ready2 !== 1'b1) begin
            failures++;
            $display("FAIL signed_idle: got digit=%h sel=%b ready=%b want 0 00000 1", dig2, sel2, ready2);
        end
    endtask

    task automatic test_back_to_back;
        int acc [3];
        int n_acc;
        int n_valid;
        n_acc = 0;
        n_valid = 0;
        @(negedge clk);
        bin0 = 16'd4321;
        blank_en0 = 1'b0;
        valid0 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (ready0 && n_acc < 3) begin
                acc[n_acc] = c;
                n_acc++;
            end
            @(posedge clk); #1;
            if (vout0) n_valid++;
            @(negedge clk);
        end
        valid0 = 1'b0;
        checks++;
        if (n_acc != 3 || acc[1] - acc[0] != 23 || acc[2] - acc[1] != 23) begin
            failures++;
            $display("FAIL b2b_spacing: got accepts=%0d gaps=%0d,%0d want 3 23,23", n_acc, acc[1] - acc[0], acc[2] - acc[1]);
        end
        checks++;
        if (n_valid < 2 || n_valid > 3 || digits0 !== 20'h04321) begin
            failures++;
            $display("FAIL b2b_results: got valids=%0d digits=%h want 2..3 04321", n_valid, digits0);
        end
    endtask

    task automatic test_abort;
        logic seen;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (ready0) break;
        end
        bin0 = 16'hFFFF;
        valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready0, vout0, neg0, ovf0} !== 4'b1000 || {digits0, blnk0, dig0, sel0} !== '0) begin
            failures++;
            $display("FAIL abort_reset: got rdy=%b v=%b neg=%b ovf=%b %h %b %h %b want 1 0 0 0 all-zero",
                     ready0, vout0, neg0, ovf0, digits0, blnk0, dig0, sel0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (vout0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || ready0 !== 1'b1 || digits0 !== 20'h0) begin
            failures++;
            $display("FAIL abort_quiet: got valid_seen=%b ready=%b digits=%h want 0 1 00000", seen, ready0, digits0);
        end
    endtask

    initial begin
        test_reset();
        test_max_and_emit();
        test_blank();
        test_ovf();
        test_signed();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
